// File: rtl/dtree_pkg.sv
// Shared definitions for the sequential decision-tree walker: node word layout,
// FSM states and the power-on node value.
package dtree_pkg;

    localparam int NODE_W    = 30;
    localparam int LEAF_BIT  = 29;
    localparam int FIDX_LSB  = 23;
    localparam int FIDX_W    = 6;
    localparam int SHAMT_LSB = 20;
    localparam int SHAMT_W   = 3;
    localparam int THR_LSB   = 12;
    localparam int THR_W     = 8;
    localparam int LEFT_LSB  = 6;
    localparam int RIGHT_LSB = 0;
    localparam int PTR_W     = 6;

    typedef enum logic [1:0] {
        LOAD,
        WALK,
        DONE
    } state_e;

    typedef struct packed {
        logic               leaf;
        logic [FIDX_W-1:0]  feat_idx;
        logic [SHAMT_W-1:0] shamt;
        logic [THR_W-1:0]   thr;
        logic [PTR_W-1:0]   left;
        logic [PTR_W-1:0]   right;
    } node_t;

    // A cleared table entry is a leaf of class 0.
    localparam logic [NODE_W-1:0] NODE_RESET = NODE_W'(1) << LEAF_BIT;

    function automatic node_t node_unpack(input logic [NODE_W-1:0] w);
        node_t n;
        n.leaf     = w[LEAF_BIT];
        n.feat_idx = w[FIDX_LSB +: FIDX_W];
        n.shamt    = w[SHAMT_LSB +: SHAMT_W];
        n.thr      = w[THR_LSB +: THR_W];
        n.left     = w[LEFT_LSB +: PTR_W];
        n.right    = w[RIGHT_LSB +: PTR_W];
        return n;
    endfunction

endpackage

// File: rtl/dtree_node_cmp.sv
// Combinational evaluation of one tree node: feature select, shift, unsigned
// threshold compare and child selection, plus illegal-pointer detection.
module dtree_node_cmp
    import dtree_pkg::*;
#(
    parameter int N_FEAT  = 45,
    parameter int FEAT_W  = 8,
    parameter int CLASS_W = 5,
    parameter int N_NODES = 64
) (
    input  node_t              node_i,
    input  logic [FEAT_W-1:0]  feat_i [N_FEAT],
    output logic               leaf_o,
    output logic [CLASS_W-1:0] class_o,
    output logic [PTR_W-1:0]   child_o,
    output logic               bad_o
);

    localparam logic [FIDX_W:0] N_FEAT_L  = N_FEAT[FIDX_W:0];
    localparam logic [PTR_W:0]  N_NODES_L = N_NODES[PTR_W:0];

    logic [FEAT_W-1:0] feat_sel;
    logic [FEAT_W-1:0] feat_shr;
    logic              go_left;
    logic              idx_bad;
    logic              child_bad;

    // Out-of-range indices select zero; they are flagged as bad anyway.
    always_comb begin
        feat_sel = '0;
        for (int i = 0; i < N_FEAT; i++) begin
            if (node_i.feat_idx == FIDX_W'(i)) begin
                feat_sel = feat_i[i];
            end
        end
    end

    assign feat_shr  = feat_sel >> node_i.shamt;
    assign go_left   = feat_shr <= node_i.thr;
    assign child_o   = go_left ? node_i.left : node_i.right;
    assign idx_bad   = {1'b0, node_i.feat_idx} >= N_FEAT_L;
    assign child_bad = {1'b0, child_o} >= N_NODES_L;
    assign bad_o     = idx_bad | child_bad;
    assign leaf_o    = node_i.leaf;
    assign class_o   = node_i.thr[CLASS_W-1:0];

endmodule

// File: rtl/dtree_seq_walker.sv
// Time-multiplexed decision-tree classifier: captures a feature vector byte by
// byte, walks a loadable node table one node per cycle, then hands off the class.
module dtree_seq_walker
    import dtree_pkg::*;
#(
    parameter int N_FEAT    = 45,
    parameter int FEAT_W    = 8,
    parameter int CLASS_W   = 5,
    parameter int N_NODES   = 64,
    parameter int NODE_AW   = 6,
    parameter int MAX_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [NODE_AW-1:0] cfg_addr,
    input  logic [NODE_W-1:0]  cfg_data,
    output logic               cfg_ready,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [FEAT_W-1:0]  s_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] out_class,
    output logic               out_err,
    output logic               busy
);

    localparam int FCNT_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int STEP_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam logic [FCNT_W-1:0] FEAT_LAST = FCNT_W'(N_FEAT - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MAX_DEPTH - 1);

    state_e               state_q, state_d;
    logic [FCNT_W-1:0]    feat_cnt_q, feat_cnt_d;
    logic [NODE_AW-1:0]   node_ptr_q, node_ptr_d;
    logic [STEP_W-1:0]    step_q, step_d;
    logic [CLASS_W-1:0]   out_class_q, out_class_d;
    logic                 out_err_q, out_err_d;

    logic [FEAT_W-1:0]    feat_q [N_FEAT];
    node_t                node_q [N_NODES];

    logic                 feat_we;
    logic                 node_we;
    node_t                cur_node;
    logic                 cmp_leaf;
    logic [CLASS_W-1:0]   cmp_class;
    logic [PTR_W-1:0]     cmp_child;
    logic                 cmp_bad;

    assign s_ready   = (state_q == LOAD);
    assign cfg_ready = (state_q == LOAD) && (feat_cnt_q == '0);
    assign out_valid = (state_q == DONE);
    assign out_class = out_class_q;
    assign out_err   = out_err_q;
    assign busy      = (state_q != LOAD) || (feat_cnt_q != '0);

    assign feat_we  = s_valid && s_ready;
    assign node_we  = cfg_we && cfg_ready;
    assign cur_node = node_q[node_ptr_q];

    dtree_node_cmp #(
        .N_FEAT  (N_FEAT),
        .FEAT_W  (FEAT_W),
        .CLASS_W (CLASS_W),
        .N_NODES (N_NODES)
    ) u_cmp (
        .node_i  (cur_node),
        .feat_i  (feat_q),
        .leaf_o  (cmp_leaf),
        .class_o (cmp_class),
        .child_o (cmp_child),
        .bad_o   (cmp_bad)
    );

    always_comb begin
        state_d     = state_q;
        feat_cnt_d  = feat_cnt_q;
        node_ptr_d  = node_ptr_q;
        step_d      = step_q;
        out_class_d = out_class_q;
        out_err_d   = out_err_q;

        unique case (state_q)
            LOAD: begin
                if (feat_we) begin
                    if (feat_cnt_q == FEAT_LAST) begin
                        feat_cnt_d = '0;
                        node_ptr_d = '0;
                        step_d     = '0;
                        state_d    = WALK;
                    end else begin
                        feat_cnt_d = feat_cnt_q + FCNT_W'(1);
                    end
                end
            end
            WALK: begin
                if (cmp_leaf) begin
                    out_class_d = cmp_class;
                    out_err_d   = 1'b0;
                    state_d     = DONE;
                end else if ((step_q == STEP_LAST) || cmp_bad) begin
                    // Depth overflow or an illegal pointer aborts the walk.
                    out_class_d = '1;
                    out_err_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    node_ptr_d = cmp_child[NODE_AW-1:0];
                    step_d     = step_q + STEP_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            feat_cnt_q  <= '0;
            node_ptr_q  <= '0;
            step_q      <= '0;
            out_class_q <= '0;
            out_err_q   <= 1'b0;
            for (int i = 0; i < N_NODES; i++) begin
                node_q[i] <= node_unpack(NODE_RESET);
            end
        end else begin
            state_q     <= state_d;
            feat_cnt_q  <= feat_cnt_d;
            node_ptr_q  <= node_ptr_d;
            step_q      <= step_d;
            out_class_q <= out_class_d;
            out_err_q   <= out_err_d;
            if (node_we) begin
                node_q[cfg_addr] <= node_unpack(cfg_data);
            end
        end
    end

    // The feature file needs no reset: every byte is rewritten before a walk.
    always_ff @(posedge clk) begin
        if (feat_we) begin
            feat_q[feat_cnt_q] <= s_data;
        end
    end

endmodule
